// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, op count and the width-independent flag bundle.
// Result structs are built per module as {logic [WIDTH-1:0] result; alu_flags_s flags;}.
package alu_pkg;

    localparam int NUM_OPS = 10;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8,
        OP_CMP = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic err;
    } alu_flags_s;

endpackage

// File: rtl/alu_core.sv
// Combinational op decode and flag generation for alu_pipe.
// ALU_PIPE_SAT_EN: ADD saturates to all-ones on carry, SUB to zero on borrow.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 4,
    parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] result,
    output alu_flags_s       flags
);
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
    logic [2*WIDTH-1:0] prod;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   r;
    logic               c, e;

    always_comb begin
        shamt = b[SH_W-1:0];
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        // Extra guard bit catches the last bit shifted out; it stays 0 for a zero shift.
        shl_ext = {1'b0, a} << shamt;
        shr_ext = {a, 1'b0} >> shamt;
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        r = '0;
        c = 1'b0;
        e = 1'b0;
        if (int'(sel) >= NUM_OPS) begin
            e = 1'b1;
        end else begin
            case (sel)
                SEL_W'(OP_ADD): begin
                    c = sum[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                    r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                    r = sum[WIDTH-1:0];
`endif
                end
                SEL_W'(OP_SUB): begin
                    c = diff[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                    r = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
                    r = diff[WIDTH-1:0];
`endif
                end
                SEL_W'(OP_AND): r = a & b;
                SEL_W'(OP_OR):  r = a | b;
                SEL_W'(OP_XOR): r = a ^ b;
                SEL_W'(OP_NOT): r = ~a;
                SEL_W'(OP_SHL): begin
                    r = shl_ext[WIDTH-1:0];
                    c = shl_ext[WIDTH];
                end
                SEL_W'(OP_SHR): begin
                    r = shr_ext[WIDTH:1];
                    c = shr_ext[0];
                end
                SEL_W'(OP_MUL): begin
                    r = prod[WIDTH-1:0];
                    c = |prod[2*WIDTH-1:WIDTH];
                end
                SEL_W'(OP_CMP): begin
                    r = {{(WIDTH-1){1'b0}}, (a < b)};
                    c = (a == b);
                end
                default: ;
            endcase
        end
        result      = r;
        flags.carry = c;
        flags.zero  = (r == '0);
        flags.err   = e;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds operands, stage 2 holds result and flags.
// Optional saturation for ADD/SUB is enabled with ALU_PIPE_SAT_EN (see alu_core).
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 4,
    parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_s       flags;
    } alu_res_s;

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    alu_res_s         res_q, res_d;
    logic [WIDTH-1:0] core_result;
    alu_flags_s       core_flags;
    logic             adv1, adv2;

    alu_core #(
        .WIDTH   (WIDTH),
        .SEL_W   (SEL_W),
        .NUM_OPS (NUM_OPS)
    ) u_core (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel_q),
        .result (core_result),
        .flags  (core_flags)
    );

    always_comb begin
        // A stage may advance whenever its downstream slot is empty or draining this cycle.
        adv2       = !s2_valid_q || out_ready;
        adv1       = !s1_valid_q || adv2;
        in_ready   = adv1 && !rst;
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d   = a;
                b_d   = b;
                sel_d = sel;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d.result = core_result;
                res_d.flags  = core_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            res_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            res_q      <= res_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = res_q.result;
    assign carry     = res_q.flags.carry;
    assign zero      = res_q.flags.zero;
    assign err       = res_q.flags.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): latency, op results, invalid op, backpressure, reset.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] sel = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       carry, zero, err;

    int n_chk  = 0;
    int n_fail = 0;

    // stream stimulus/expectation tables
    logic [3:0] s_sel [8];
    logic [7:0] s_a [8];
    logic [7:0] s_b [8];
    logic [7:0] e_res [8];
    logic       e_c [8];
    logic       e_z [8];
    logic       e_e [8];
    int         cyc_used;
    int         saw_stall;

    alu_pipe #(.WIDTH(8), .SEL_W(4), .NUM_OPS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single beat with out_ready high; called at posedge+1.
    task automatic send_chk(input string tag, input logic [3:0] s, input logic [7:0] ia,
                            input logic [7:0] ib, input logic [7:0] er, input logic ec,
                            input logic ez, input logic ee);
        in_valid = 1'b1; sel = s; a = ia; b = ib; out_ready = 1'b1;
        @(negedge clk); chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk({tag, ".lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".result"}, 64'(result), 64'(er));
        chk({tag, ".carry"}, 64'(carry), 64'(ec));
        chk({tag, ".zero"}, 64'(zero), 64'(ez));
        chk({tag, ".err"}, 64'(err), 64'(ee));
        @(posedge clk); #1;
    endtask

    // Streams n beats from the tables with out_ready following pat[cyc%4]; called at posedge+1.
    task automatic stream(input string tag, input int n, input logic [3:0] pat);
        int n_tx = 0, n_rx = 0;
        logic held = 1'b0;
        logic [7:0] h_res = '0;
        logic [2:0] h_fl = '0;
        cyc_used = 0;
        saw_stall = 0;
        for (int cyc = 0; cyc < 200 && n_rx < n; cyc++) begin
            in_valid = (n_tx < n);
            if (n_tx < n) begin
                sel = s_sel[n_tx]; a = s_a[n_tx]; b = s_b[n_tx];
            end
            out_ready = pat[cyc % 4];
            @(negedge clk);
            chk({tag, ".in_ready"}, 64'(in_ready), 64'(!((n_tx - n_rx) == 2 && !out_ready)));
            if (!in_ready) saw_stall = 1;
            if (held) begin
                chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
                chk({tag, ".hold_data"}, 64'({result, carry, zero, err}), 64'({h_res, h_fl}));
            end
            if (out_valid && out_ready) begin
                if (n_rx < n) begin
                    chk({tag, ".result"}, 64'(result), 64'(e_res[n_rx]));
                    chk({tag, ".flags"}, 64'({carry, zero, err}),
                        64'({e_c[n_rx], e_z[n_rx], e_e[n_rx]}));
                end
                n_rx++;
            end
            held  = out_valid && !out_ready;
            h_res = result;
            h_fl  = {carry, zero, err};
            if (in_valid && in_ready) n_tx++;
            cyc_used = cyc + 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({tag, ".received"}, 64'(n_rx), 64'(n));
        out_ready = 1'b1;
        @(negedge clk); chk({tag, ".no_extra"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.outs", 64'({out_valid, result, carry, zero, err}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("post_rst.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // single-beat ops
        send_chk("add", OP_ADD, 8'h10, 8'h22, 8'h32, 1'b0, 1'b0, 1'b0);
`ifdef ALU_PIPE_SAT_EN
        send_chk("add_ovf", OP_ADD, 8'hFF, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        send_chk("sub_brw", OP_SUB, 8'h05, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0);
`else
        send_chk("add_ovf", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        send_chk("sub_brw", OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0);
`endif
        send_chk("sub", OP_SUB, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0, 1'b0);
        send_chk("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        send_chk("or", OP_OR, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_chk("xor", OP_XOR, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
        send_chk("not", OP_NOT, 8'h5A, 8'h33, 8'hA5, 1'b0, 1'b0, 1'b0);
        send_chk("shl", OP_SHL, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
        send_chk("shl0", OP_SHL, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b0);
        send_chk("shr", OP_SHR, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0);
        send_chk("shr3", OP_SHR, 8'h84, 8'h03, 8'h10, 1'b1, 1'b0, 1'b0);
        send_chk("mul", OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
        send_chk("mul_lo", OP_MUL, 8'h07, 8'h06, 8'h2A, 1'b0, 1'b0, 1'b0);
        send_chk("cmp_eq", OP_CMP, 8'h03, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0);
        send_chk("cmp_lt", OP_CMP, 8'h02, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0);
        send_chk("inv10", 4'd10, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1);
        send_chk("inv15", 4'd15, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);

        // invalid opcode between two ADDs, full throughput
        s_sel[0] = OP_ADD; s_a[0] = 8'h01; s_b[0] = 8'h02;
        e_res[0] = 8'h03; e_c[0] = 1'b0; e_z[0] = 1'b0; e_e[0] = 1'b0;
        s_sel[1] = 4'd12;  s_a[1] = 8'h55; s_b[1] = 8'hAA;
        e_res[1] = 8'h00; e_c[1] = 1'b0; e_z[1] = 1'b1; e_e[1] = 1'b1;
        s_sel[2] = OP_ADD; s_a[2] = 8'h7F; s_b[2] = 8'h01;
        e_res[2] = 8'h80; e_c[2] = 1'b0; e_z[2] = 1'b0; e_e[2] = 1'b0;
        stream("inv_stream", 3, 4'b1111);
        chk("inv_stream.cycles", 64'(cyc_used), 64'd5);

        // backpressure: out_ready 1,0,0,1 repeating
        s_a = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hF0, 8'h80};
        s_b = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h10, 8'h80};
        e_res = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h00, 8'h00};
        e_c = '{0, 0, 0, 0, 0, 0, 1, 1};
        e_z = '{0, 0, 0, 0, 0, 0, 1, 1};
        e_e = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) s_sel[i] = OP_ADD;
`ifdef ALU_PIPE_SAT_EN
        e_res[6] = 8'hFF; e_z[6] = 1'b0;
        e_res[7] = 8'hFF; e_z[7] = 1'b0;
`endif
        stream("bp_stream", 8, 4'b1001);
        chk("bp_stream.stalled", 64'(saw_stall), 64'd1);

        // mid-op reset: two beats parked, then one reset cycle
        in_valid = 1'b1; out_ready = 1'b0; sel = OP_ADD; a = 8'h01; b = 8'h01;
        @(posedge clk); #1 a = 8'h02;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("mid.parked", 64'(out_valid), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); chk("mid.rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid.outs", 64'({out_valid, result, carry, zero, err}), 64'd0);
        chk("mid.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("mid.flushed", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        send_chk("post_mid", OP_ADD, 8'h20, 8'h03, 8'h23, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle mux ALU.
- Generalised data width and an extended op set.
- Adds valid/ready handshakes on input and output, full throughput under backpressure, status flags, and explicit invalid-op reporting.
- Sits between a stimulus source and a result consumer; all flags travel in lockstep with the result.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 4..64).
- SEL_W, 4, opcode width; opcodes at or above NUM_OPS are invalid.
- NUM_OPS, 10, count of implemented opcodes.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  SEL_W  opcode.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  WIDTH  operation result.
- carry  out  1  carry/borrow/overflow flag.
- zero  out  1  result == 0.
- err  out  1  opcode was invalid.

Behaviour:
- Reset: the already-decided rule is one clock, with synchronous active-high reset on clk/rst. While rst=1 at a clock edge:
  - s1_valid=0 and s2_valid=0.
  - result, carry, zero and err all become 0; out_valid=0.
  - in_ready=0 while rst is high, and 1 on the first cycle after.
  - In-flight beats are discarded, never emitted.
- Handshake: a beat transfers on the input when in_valid&&in_ready, and on the output when out_valid&&out_ready.
  - Once out_valid is asserted, result, carry, zero and err hold stable until the beat is accepted.
- Pipeline:
  - Stage 1 registers a, b and sel.
  - Stage 2 registers the computed result and flags.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 && !rst.
  - Latency: 2 cycles from input acceptance to out_valid when unstalled.
  - Throughput: one beat per cycle with out_ready held high.
  - No bubbles are inserted and no beats are dropped under any out_ready pattern.
  - Beats emerge in acceptance order.
- Ops (sel):
  - 0 ADD: {carry,result}=a+b.
  - 1 SUB: result=a-b, carry=(a<b) unsigned borrow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT (~a; b ignored): carry=0.
  - 6 SHL: a<<b[$clog2(WIDTH)-1:0]; carry = last bit shifted out (0 if shift is 0).
  - 7 SHR: logical a>>shamt; carry = last bit shifted out.
  - 8 MUL: result = low WIDTH bits of a*b; carry = OR of the high WIDTH bits.
  - 9 CMP: result = {WIDTH-1 zeros, a<b} unsigned; carry = (a==b).
- Invalid opcode (sel>=NUM_OPS): result=0, carry=0, zero=1, err=1. The beat is still emitted in order; the pipeline is not stalled.
- zero is computed from the final (post-saturation) result.
- Simultaneous events:
  - Input accept and output accept in the same cycle are both honoured; the pipeline shifts.
  - rst dominates all handshakes.

Optional Feature:
- Macro ALU_PIPE_SAT_EN.
- When defined: ADD saturates to all-ones on carry, and SUB saturates to 0 on borrow. carry still reports the raw overflow/borrow.
- When undefined: ADD and SUB wrap modulo 2^WIDTH.
- All other ops are unaffected either way.

Decomposition:
- Shared package alu_pkg holds:
  - enum alu_op_e (ADD..CMP) and the NUM_OPS constant.
  - A packed struct alu_res_s {result, carry, zero, err}, parametrised via a WIDTH-typedef pattern.
- The same package is consumed by the testbench predictor.
- One natural sub-module, alu_core: purely combinational op decode and flag generation. alu_pipe instantiates it between stage 1 and stage 2 and owns the handshake registers.

Test Plan (WIDTH=8):
- Sanity latency: ADD a=0x10 b=0x22 with out_ready=1 -> out_valid exactly 2 cycles after acceptance; result=0x32, carry=0, zero=0, err=0.
- Overflow/borrow: ADD 0xFF+0x01 -> result=0x00, carry=1, zero=1 (SAT_EN: result=0xFF, zero=0). SUB 0x05-0x07 -> result=0xFE, carry=1 (SAT_EN: 0x00).
- Shift/mul/cmp:
  - SHL 0x81 by 1 -> 0x02, carry=1.
  - MUL 0x10*0x10 -> 0x00, carry=1.
  - CMP 0x03,0x03 -> 0x00, carry=1.
- Invalid opcode: sel=12 between two ADDs -> middle beat has result=0, zero=1, err=1; neighbouring beats are correct and in order.
- Backpressure: stream 8 ADDs with out_ready toggling 1,0,0,1,… -> no loss or duplication; in_ready drops only when both stages are full; outputs stay stable while stalled.
- Mid-op reset: accept 2 beats, assert rst for 1 cycle -> no out_valid for those beats; all outputs 0 during reset; the next beat after reset completes in 2 cycles.
